column_sweep_scheduler: RTL and testbench

Per-rotation-slot sequencer sitting between the rotation tracker (`dtheta`) and the HUB75 driver. Each time the rotational slot changes it sweeps scan indices 0..SCAN_RATE-1 and offers each index to the downstream column datapath and HUB75 driver over a valid/ready handshake. It honours the per-slot scanline mask and restarts cleanly when the rotation outruns the panel. It replaces the ad-hoc ready-edge logic in the frame path with an explicit FSM and an overrun counter.

---
 rtl/column_sweep_scheduler.sv | 169 ++++++++++++++++
 tb/tb_column_sweep_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/column_sweep_scheduler.sv
// Purpose : per-rotation-slot sequencer; sweeps scan indices 0..SCAN_RATE-1 for each new theta slot
// Latency : theta change (IDLE) to first col_valid = 2 cycles; at least 2 cycles per offered index
// Backpr. : an offer is held stable until hub75_ready; a theta change mid-sweep aborts only after the transfer
//
// Optional feature macro: SKIP_MASK_EN
//   defined   -> masked indices are skipped (one cycle each, no handshake); col_blank tied to 0
//   undefined -> every index is offered; masked indices are offered with col_blank = 1
//
// Ports:
//   clk_in, rst_n_in    clock, synchronous active-low reset
//   dtheta              current rotational slot from the rotation tracker
//   col_mask            per-scan-index lit mask for the current slot (sampled in SCAN only)
//   hub75_ready         driver accepts the offered column this cycle
//   col_valid/col_index/col_blank   column offer to the datapath / driver
//   slot_theta          theta latched for the sweep in progress
//   sweep_done          one-cycle pulse when a sweep covers all indices
//   overrun_count       saturating count of aborted sweeps
//   busy                sequencer is not idle
module column_sweep_scheduler #(
    parameter int ROTATIONAL_RES = 256,
    parameter int SCAN_RATE      = 32,
    parameter int OVR_W          = 8
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
    input  logic [SCAN_RATE-1:0]              col_mask,
    input  logic                              hub75_ready,
    output logic                              col_valid,
    output logic [$clog2(SCAN_RATE)-1:0]      col_index,
    output logic                              col_blank,
    output logic [$clog2(ROTATIONAL_RES)-1:0] slot_theta,
    output logic                              sweep_done,
    output logic [OVR_W-1:0]                  overrun_count,
    output logic                              busy
);

    localparam int TW = $clog2(ROTATIONAL_RES);
    localparam int IW = $clog2(SCAN_RATE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_OFFER = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_primed;
    logic [IW-1:0]    r_idx;
    logic             r_col_valid;
    logic [IW-1:0]    r_col_index;
    logic [TW-1:0]    r_slot_theta;
    logic             r_sweep_done;
    logic [OVR_W-1:0] r_overrun_count;
    logic             r_busy;
`ifndef SKIP_MASK_EN
    logic             r_col_blank;
`endif

    logic w_theta_chg;
    logic w_last;
    logic w_xfer;
    logic w_ovr_sat;

    assign w_theta_chg = (dtheta != r_slot_theta);
    assign w_last      = (r_idx == IW'(SCAN_RATE - 1));
    assign w_xfer      = r_col_valid & hub75_ready;
    assign w_ovr_sat   = (r_overrun_count == {OVR_W{1'b1}});

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state         <= S_IDLE;
            r_primed        <= 1'b0;
            r_idx           <= '0;
            r_col_valid     <= 1'b0;
            r_col_index     <= '0;
            r_slot_theta    <= '0;
            r_sweep_done    <= 1'b0;
            r_overrun_count <= '0;
            r_busy          <= 1'b0;
`ifndef SKIP_MASK_EN
            r_col_blank     <= 1'b0;
`endif
        end else begin
            r_sweep_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // primed=0 forces the very first sweep even if dtheta matches the reset theta
                    if (!r_primed || w_theta_chg) begin
                        r_slot_theta <= dtheta;
                        r_idx        <= '0;
                        r_primed     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_theta_chg) begin
                        // rotation outran the panel: restart for the new slot
                        if (!w_ovr_sat) r_overrun_count <= r_overrun_count + OVR_W'(1);
                        r_slot_theta <= dtheta;
                        r_idx        <= '0;
                    end else if (col_mask[r_idx]) begin
                        r_col_index <= r_idx;
                        r_col_valid <= 1'b1;
`ifndef SKIP_MASK_EN
                        r_col_blank <= 1'b0;
`endif
                        r_state     <= S_OFFER;
                    end else begin
`ifdef SKIP_MASK_EN
                        if (w_last) begin
                            r_sweep_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
`else
                        r_col_index <= r_idx;
                        r_col_valid <= 1'b1;
                        r_col_blank <= 1'b1;
                        r_state     <= S_OFFER;
`endif
                    end
                end
                S_OFFER: begin
                    // offer is never withdrawn; an abort waits for the transfer
                    if (w_xfer) begin
                        r_col_valid <= 1'b0;
                        if (w_theta_chg) begin
                            if (!w_ovr_sat) r_overrun_count <= r_overrun_count + OVR_W'(1);
                            r_slot_theta <= dtheta;
                            r_idx        <= '0;
                            r_state      <= S_SCAN;
                        end else if (w_last) begin
                            r_sweep_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign col_valid     = r_col_valid;
    assign col_index     = r_col_index;
    assign slot_theta    = r_slot_theta;
    assign sweep_done    = r_sweep_done;
    assign overrun_count = r_overrun_count;
    assign busy          = r_busy;
`ifdef SKIP_MASK_EN
    assign col_blank     = 1'b0;
`else
    assign col_blank     = r_col_blank;
`endif

endmodule

// File: tb/tb_column_sweep_scheduler.sv
// Purpose : directed self-checking bench for column_sweep_scheduler
// Latency : outputs sampled on the falling edge, inputs driven on the falling edge
// Backpr. : hub75_ready is driven by the bench to create stalls
module tb_column_sweep_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [7:0]  dtheta;
    logic [31:0] col_mask;
    logic        hub75_ready;
    logic        col_valid;
    logic [4:0]  col_index;
    logic        col_blank;
    logic [7:0]  slot_theta;
    logic        sweep_done;
    logic [7:0]  overrun_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // sweep capture filled by collect()
    int   n_xfer;
    int   n_done;
    int   done_at;
    int   xi [64];
    logic xb [64];

    column_sweep_scheduler dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .dtheta        (dtheta),
        .col_mask      (col_mask),
        .hub75_ready   (hub75_ready),
        .col_valid     (col_valid),
        .col_index     (col_index),
        .col_blank     (col_blank),
        .slot_theta    (slot_theta),
        .sweep_done    (sweep_done),
        .overrun_count (overrun_count),
        .busy          (busy)
    );

    always #5 clk_in = ~clk_in;

    // Steps cycles, logging transfers and sweep_done; c counts rising edges since the call.
    task automatic collect(input int budget);
        n_xfer  = 0;
        n_done  = 0;
        done_at = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (col_valid && hub75_ready) begin
                if (n_xfer < 64) begin
                    xi[n_xfer] = int'(col_index);
                    xb[n_xfer] = col_blank;
                end
                n_xfer++;
            end
            if (sweep_done) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            if (done_at >= 0 && c >= done_at + 2) break;
        end
    endtask

    task automatic test_reset;
        rst_n_in    = 1'b0;
        dtheta      = 8'd5;
        col_mask    = 32'hFFFF_FFFF;
        hub75_ready = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (col_valid !== 1'b0) begin errors++; $display("FAIL reset col_valid got=%b exp=0", col_valid); end
        checks++; if (col_index !== 5'd0) begin errors++; $display("FAIL reset col_index got=%0d exp=0", col_index); end
        checks++; if (col_blank !== 1'b0) begin errors++; $display("FAIL reset col_blank got=%b exp=0", col_blank); end
        checks++; if (slot_theta !== 8'd0) begin errors++; $display("FAIL reset slot_theta got=%0d exp=0", slot_theta); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset sweep_done got=%b exp=0", sweep_done); end
        checks++; if (overrun_count !== 8'd0) begin errors++; $display("FAIL reset overrun_count got=%0d exp=0", overrun_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", busy); end
    endtask

    task automatic test_first_sweep;
        int bad;
        rst_n_in = 1'b1;
        collect(200);
        bad = 0;
        for (int i = 0; i < 32 && i < n_xfer; i++) if (xi[i] != i) bad++;
        checks++; if (slot_theta !== 8'd5) begin errors++; $display("FAIL first slot_theta got=%0d exp=5", slot_theta); end
        checks++; if (n_xfer != 32) begin errors++; $display("FAIL first xfer_count got=%0d exp=32", n_xfer); end
        checks++; if (bad != 0) begin errors++; $display("FAIL first index_order bad=%0d exp=0", bad); end
        // cycle 1 is the idle cycle after release, so done after edge 65 is cycle 66
        checks++; if (done_at + 1 != 66) begin errors++; $display("FAIL first done_cycle got=%0d exp=66", done_at + 1); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL first done_count got=%0d exp=1", n_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_mask;
        logic [31:0] blank_map;
        int          bad;
        col_mask = 32'h0000_0101;
        dtheta   = 8'd7;
        collect(200);
        checks++; if (n_done != 1) begin errors++; $display("FAIL mask done_count got=%0d exp=1", n_done); end
`ifdef SKIP_MASK_EN
        checks++; if (n_xfer != 2) begin errors++; $display("FAIL mask_skip xfer_count got=%0d exp=2", n_xfer); end
        checks++; if (n_xfer >= 2 && (xi[0] != 0 || xi[1] != 8)) begin errors++; $display("FAIL mask_skip indices got=%0d,%0d exp=0,8", xi[0], xi[1]); end
        // SCAN entered on edge 1, DONE entered on edge done_at
        checks++; if (done_at - 1 != 34) begin errors++; $display("FAIL mask_skip sweep_len got=%0d exp=34", done_at - 1); end
`else
        blank_map = '0;
        bad = 0;
        for (int i = 0; i < 32 && i < n_xfer; i++) begin
            blank_map[i] = xb[i];
            if (xi[i] != i) bad++;
        end
        checks++; if (n_xfer != 32) begin errors++; $display("FAIL mask_blank xfer_count got=%0d exp=32", n_xfer); end
        checks++; if (bad != 0) begin errors++; $display("FAIL mask_blank index_order bad=%0d exp=0", bad); end
        checks++; if (blank_map !== 32'hFFFF_FEFE) begin errors++; $display("FAIL mask_blank blank_map got=%h exp=fffffefe", blank_map); end
        checks++; if (done_at != 65) begin errors++; $display("FAIL mask_blank done_edge got=%0d exp=65", done_at); end
`endif
        col_mask = 32'hFFFF_FFFF;
    endtask

    task automatic test_backpressure;
        int seen = 0;
        int stall = 0;
        int stable_bad = 0;
        int n3 = 0;
        int done = 0;
        hub75_ready = 1'b1;
        dtheta      = 8'd9;
        for (int c = 0; c < 300 && done == 0; c++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (col_valid && col_index == 5'd3 && seen == 0) begin
                seen        = 1;
                hub75_ready = 1'b0;
                stall       = 10;
            end else if (stall > 0) begin
                if (col_valid !== 1'b1 || col_index !== 5'd3) stable_bad++;
                stall--;
                if (stall == 0) hub75_ready = 1'b1;
            end
            if (col_valid && hub75_ready && col_index == 5'd3) n3++;
            if (sweep_done) done = 1;
        end
        hub75_ready = 1'b1;
        checks++; if (seen != 1) begin errors++; $display("FAIL bp offer3_seen got=%0d exp=1", seen); end
        checks++; if (stable_bad != 0) begin errors++; $display("FAIL bp stall_stability bad=%0d exp=0", stable_bad); end
        checks++; if (n3 != 1) begin errors++; $display("FAIL bp idx3_transfers got=%0d exp=1", n3); end
        checks++; if (done != 1) begin errors++; $display("FAIL bp sweep_done_seen got=%0d exp=1", done); end
    endtask

    task automatic test_overrun;
        int seen = 0;
        int nd = 0;
        int stable_bad = 0;
        hub75_ready = 1'b1;
        dtheta      = 8'd5;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (sweep_done) nd++;
            if (col_valid && col_index == 5'd12) begin
                seen        = 1;
                hub75_ready = 1'b0;
                dtheta      = 8'd6;
                break;
            end
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL ovr offer12_seen got=%0d exp=1", seen); end
        repeat (3) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (col_valid !== 1'b1 || col_index !== 5'd12 || slot_theta !== 8'd5) stable_bad++;
        end
        checks++; if (stable_bad != 0) begin errors++; $display("FAIL ovr stall_hold bad=%0d exp=0", stable_bad); end
        hub75_ready = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        if (sweep_done) nd++;
        checks++; if (slot_theta !== 8'd6) begin errors++; $display("FAIL ovr slot_theta got=%0d exp=6", slot_theta); end
        checks++; if (overrun_count !== 8'd1) begin errors++; $display("FAIL ovr count got=%0d exp=1", overrun_count); end
        checks++; if (col_valid !== 1'b0) begin errors++; $display("FAIL ovr valid_after_xfer got=%b exp=0", col_valid); end
        @(posedge clk_in);
        @(negedge clk_in);
        if (sweep_done) nd++;
        checks++; if (col_valid !== 1'b1 || col_index !== 5'd0) begin errors++; $display("FAIL ovr restart valid=%b idx=%0d exp=1,0", col_valid, col_index); end
        checks++; if (nd != 0) begin errors++; $display("FAIL ovr sweep_done_count got=%0d exp=0", nd); end
        // every cycle a new theta: each edge aborts once more
        for (int i = 0; i < 300; i++) begin
            dtheta = dtheta + 8'd1;
            @(posedge clk_in);
            @(negedge clk_in);
            if (i == 99) begin
                checks++; if (overrun_count !== 8'd101) begin errors++; $display("FAIL ovr count_101 got=%0d exp=101", overrun_count); end
            end
        end
        checks++; if (overrun_count !== 8'd255) begin errors++; $display("FAIL ovr saturate got=%0d exp=255", overrun_count); end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        int bad;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (col_valid) begin
                seen = 1;
                break;
            end
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL rstmid offer_seen got=%0d exp=1", seen); end
        rst_n_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (col_valid !== 1'b0) begin errors++; $display("FAIL rstmid col_valid got=%b exp=0", col_valid); end
        checks++; if (col_index !== 5'd0) begin errors++; $display("FAIL rstmid col_index got=%0d exp=0", col_index); end
        checks++; if (slot_theta !== 8'd0) begin errors++; $display("FAIL rstmid slot_theta got=%0d exp=0", slot_theta); end
        checks++; if (overrun_count !== 8'd0) begin errors++; $display("FAIL rstmid overrun_count got=%0d exp=0", overrun_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy got=%b exp=0", busy); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL rstmid sweep_done got=%b exp=0", sweep_done); end
        dtheta   = 8'd20;
        rst_n_in = 1'b1;
        collect(200);
        bad = 0;
        for (int i = 0; i < 32 && i < n_xfer; i++) if (xi[i] != i) bad++;
        checks++; if (slot_theta !== 8'd20) begin errors++; $display("FAIL rstmid new_theta got=%0d exp=20", slot_theta); end
        checks++; if (n_xfer != 32 || bad != 0) begin errors++; $display("FAIL rstmid fresh_sweep xfers=%0d bad=%0d exp=32,0", n_xfer, bad); end
        checks++; if (done_at != 65) begin errors++; $display("FAIL rstmid done_edge got=%0d exp=65", done_at); end
    endtask

    initial begin
        test_reset();
        test_first_sweep();
        test_mask();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
